// File: rtl/spi_reg_bridge_if.sv
// Byte-stream and register-bus signals of the SPI register bridge.
// The bridge takes the master modport; the SPI front-end and register file take slave.
interface spi_reg_bridge_if #(
   parameter int unsigned ADDR_W = 7
);
   logic              cs_active;
   logic [7:0]        rx_byte;
   logic              rx_valid;
   logic [7:0]        tx_byte;
   logic              tx_load;
   logic [ADDR_W-1:0] reg_addr;
   logic [7:0]        reg_wdata;
   logic              reg_we;
   logic              reg_re;
   logic [7:0]        reg_rdata;
   logic              overrun;
   logic [15:0]       frame_cnt;

   modport master (
      input  cs_active, rx_byte, rx_valid, reg_rdata,
      output tx_byte, tx_load, reg_addr, reg_wdata, reg_we, reg_re, overrun, frame_cnt
   );

   modport slave (
      output cs_active, rx_byte, rx_valid, reg_rdata,
      input  tx_byte, tx_load, reg_addr, reg_wdata, reg_we, reg_re, overrun, frame_cnt
   );
endinterface

// File: rtl/spi_reg_bridge.sv
// Turns the SPI slave byte stream into register-bus transactions: a command byte
// (R/nW + start address) followed by auto-incrementing write or read data bytes.
module spi_reg_bridge #(
   parameter int unsigned ADDR_W  = 7,
   parameter logic [7:0]  IDLE_TX = 8'hFF
) (
   input logic              clk_i,
   input logic              rst_i,
   spi_reg_bridge_if.master bus
);
   typedef enum logic [2:0] {IDLE, CMD, WR_DATA, RD_FETCH, RD_DATA} state_e;

   state_e            state_q, state_d;
   logic              cs_prev_q;
   logic              armed_q, armed_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic              we_q, we_d;
   logic              re_q, re_d;
   logic [7:0]        tx_byte_q, tx_byte_d;
   logic              tx_load_q, tx_load_d;
   logic              overrun_q, overrun_d;
   logic [15:0]       frame_cnt_q, frame_cnt_d;

   logic frame_start;
   logic frame_end;

   // armed_q stays low after reset until CS is seen inactive, so a frame
   // already running at reset release is never picked up half-way.
   assign frame_start = bus.cs_active & ~cs_prev_q & armed_q;
   assign frame_end   = ~bus.cs_active & cs_prev_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= IDLE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (state_q == IDLE) begin
         if (frame_start) state_d = CMD;
      end else if (frame_end) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            CMD:      if (bus.rx_valid) state_d = bus.rx_byte[7] ? RD_FETCH : WR_DATA;
            RD_FETCH: if (!re_q) state_d = RD_DATA;
            RD_DATA:  if (bus.rx_valid) state_d = RD_FETCH;
            default:  state_d = state_q;
         endcase
      end
   end

   always_comb begin
      // NOTE: every _d gets a default first, so no path through this block infers a latch.
      addr_d      = we_q ? addr_q + ADDR_W'(1) : addr_q;
      wdata_d     = wdata_q;
      we_d        = 1'b0;
      re_d        = 1'b0;
      tx_byte_d   = tx_byte_q;
      tx_load_d   = 1'b0;
      overrun_d   = overrun_q;
      frame_cnt_d = frame_cnt_q;
      armed_d     = armed_q | ~bus.cs_active;

      if (state_q != IDLE && frame_end) begin
         frame_cnt_d = frame_cnt_q + 16'd1;
         tx_byte_d   = IDLE_TX;
         tx_load_d   = 1'b1;
      end else begin
         unique case (state_q)
            CMD: if (bus.rx_valid) begin
               addr_d = bus.rx_byte[ADDR_W-1:0];
               re_d   = bus.rx_byte[7];
            end
            RD_FETCH: begin
               if (bus.rx_valid) overrun_d = 1'b1;
               // re_q low means this is the cycle the register file answers.
               if (!re_q) begin
                  tx_byte_d = bus.reg_rdata;
                  tx_load_d = 1'b1;
               end
            end
            RD_DATA: if (bus.rx_valid) begin
               addr_d = addr_q + ADDR_W'(1);
               re_d   = 1'b1;
            end
            WR_DATA: if (bus.rx_valid) begin
               wdata_d   = bus.rx_byte;
               we_d      = 1'b1;
               tx_byte_d = bus.rx_byte;
               tx_load_d = 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cs_prev_q   <= 1'b0;
         armed_q     <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         we_q        <= 1'b0;
         re_q        <= 1'b0;
         tx_byte_q   <= IDLE_TX;
         tx_load_q   <= 1'b0;
         overrun_q   <= 1'b0;
         frame_cnt_q <= '0;
      end else begin
         // NOTE: non-blocking, so every register updates from the same pre-edge values.
         cs_prev_q   <= bus.cs_active;
         armed_q     <= armed_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         we_q        <= we_d;
         re_q        <= re_d;
         tx_byte_q   <= tx_byte_d;
         tx_load_q   <= tx_load_d;
         overrun_q   <= overrun_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   assign bus.tx_byte   = tx_byte_q;
   assign bus.tx_load   = tx_load_q;
   assign bus.reg_addr  = addr_q;
   assign bus.reg_wdata = wdata_q;
   assign bus.reg_we    = we_q;
   assign bus.reg_re    = re_q;
   assign bus.overrun   = overrun_q;
   assign bus.frame_cnt = frame_cnt_q;
endmodule

// File: tb/tb_spi_reg_bridge.sv
// Scoreboard bench for spi_reg_bridge: expected strobes and tx loads are queued as
// bytes are driven and compared when the DUT produces them.
module tb_spi_reg_bridge;
   localparam int ADDR_W = 7;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_reg_bridge_if #(.ADDR_W(ADDR_W)) bus ();

   spi_reg_bridge #(.ADDR_W(ADDR_W), .IDLE_TX(8'hFF)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   // Register file model: registered read, data valid the cycle after reg_re.
   logic [7:0] mem [128];
   always @(posedge clk) begin
      if (bus.reg_we) mem[bus.reg_addr] <= bus.reg_wdata;
      if (bus.reg_re) bus.reg_rdata <= mem[bus.reg_addr];
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct { logic [6:0] addr; logic [7:0] data; } wr_t;
   typedef struct { logic [7:0] data; int at; } tx_t;

   wr_t        wq [$];
   logic [6:0] rq [$];
   tx_t        tq [$];

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   wr_t        w_exp;
   logic [6:0] r_exp;
   tx_t        t_exp;

   always @(negedge clk) begin
      if (bus.reg_we) begin
         check("we_not_re", 32'(bus.reg_re), 32'd0);
         if (wq.size() == 0) check("we_spurious", 32'(bus.reg_we), 32'd0);
         else begin
            w_exp = wq.pop_front();
            check("we_addr", 32'(bus.reg_addr), 32'(w_exp.addr));
            check("we_data", 32'(bus.reg_wdata), 32'(w_exp.data));
         end
      end
      if (bus.reg_re) begin
         if (rq.size() == 0) check("re_spurious", 32'(bus.reg_re), 32'd0);
         else begin
            r_exp = rq.pop_front();
            check("re_addr", 32'(bus.reg_addr), 32'(r_exp));
         end
      end
      if (bus.tx_load) begin
         if (tq.size() == 0) check("tx_spurious", 32'(bus.tx_load), 32'd0);
         else begin
            t_exp = tq.pop_front();
            check("tx_byte", 32'(bus.tx_byte), 32'(t_exp.data));
            check("tx_cycle", 32'(cyc), 32'(t_exp.at));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Returns the cycle number right after the edge that accepted the byte.
   task automatic send_byte(input logic [7:0] b, output int n);
      @(posedge clk); #1;
      bus.rx_byte  = b;
      bus.rx_valid = 1'b1;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      n = cyc;
   endtask

   task automatic wr_byte(input logic [6:0] a, input logic [7:0] b);
      int n;
      send_byte(b, n);
      wq.push_back(wr_t'{a, b});
      tq.push_back(tx_t'{b, n});
      tick(2);
   endtask

   // Command or dummy byte in a read frame: fetch of address a, loaded 2 cycles later.
   task automatic rd_byte(input logic [7:0] b, input logic [6:0] a, input logic [7:0] exp);
      int n;
      send_byte(b, n);
      rq.push_back(a);
      tq.push_back(tx_t'{exp, n + 2});
      tick(4);
   endtask

   task automatic cmd_byte(input logic [7:0] b);
      int n;
      send_byte(b, n);
      tick(2);
   endtask

   task automatic frame_begin();
      @(posedge clk); #1;
      bus.cs_active = 1'b1;
   endtask

   task automatic frame_end(input bit expect_load);
      @(posedge clk); #1;
      bus.cs_active = 1'b0;
      @(posedge clk); #1;
      if (expect_load) tq.push_back(tx_t'{8'hFF, cyc});
      tick(2);
   endtask

   task automatic check_reset_values();
      check("rst_tx_byte", 32'(bus.tx_byte), 32'hFF);
      check("rst_tx_load", 32'(bus.tx_load), 32'd0);
      check("rst_reg_we", 32'(bus.reg_we), 32'd0);
      check("rst_reg_re", 32'(bus.reg_re), 32'd0);
      check("rst_reg_addr", 32'(bus.reg_addr), 32'd0);
      check("rst_reg_wdata", 32'(bus.reg_wdata), 32'd0);
      check("rst_overrun", 32'(bus.overrun), 32'd0);
      check("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst           = 1'b1;
      bus.cs_active = 1'b0;
      bus.rx_valid  = 1'b0;
      bus.rx_byte   = 8'h00;
      for (int i = 0; i < 128; i++) mem[i] = 8'h00;
      mem[7'h10] = 8'hA0;
      mem[7'h11] = 8'hA1;
      mem[7'h12] = 8'hA2;
      mem[7'h13] = 8'hA3;
      tick(3);
      check_reset_values();
      rst = 1'b0;
      tick(2);

      // Write burst 0x05: 0x11, 0x22, 0x33
      frame_begin();
      cmd_byte(8'h05);
      wr_byte(7'h05, 8'h11);
      wr_byte(7'h06, 8'h22);
      wr_byte(7'h07, 8'h33);
      frame_end(1);
      check("frame_cnt_1", 32'(bus.frame_cnt), 32'd1);

      // Read burst from 0x10
      frame_begin();
      rd_byte(8'h90, 7'h10, 8'hA0);
      rd_byte(8'h00, 7'h11, 8'hA1);
      rd_byte(8'h00, 7'h12, 8'hA2);
      rd_byte(8'h00, 7'h13, 8'hA3);
      frame_end(1);
      check("frame_cnt_2", 32'(bus.frame_cnt), 32'd2);
      check("no_overrun", 32'(bus.overrun), 32'd0);

      // Address wrap on write, then read the two locations back across the wrap
      frame_begin();
      cmd_byte(8'h7F);
      wr_byte(7'h7F, 8'hAA);
      wr_byte(7'h00, 8'hBB);
      frame_end(1);
      frame_begin();
      rd_byte(8'hFF, 7'h7F, 8'hAA);
      rd_byte(8'h00, 7'h00, 8'hBB);
      frame_end(1);
      check("frame_cnt_4", 32'(bus.frame_cnt), 32'd4);

      // CS drops together with a data byte: byte dropped, idle byte offered
      frame_begin();
      cmd_byte(8'h40);
      wr_byte(7'h40, 8'h5C);
      @(posedge clk); #1;
      bus.cs_active = 1'b0;
      bus.rx_byte   = 8'h77;
      bus.rx_valid  = 1'b1;
      @(posedge clk); #1;
      bus.rx_valid = 1'b0;
      tq.push_back(tx_t'{8'hFF, cyc});
      tick(2);
      check("early_rel_tx", 32'(bus.tx_byte), 32'hFF);
      check("frame_cnt_5", 32'(bus.frame_cnt), 32'd5);
      send_byte(8'h12, n);          // outside any frame: must be ignored
      tick(3);

      // Overrun: byte arrives the cycle after reg_re of a fetch
      frame_begin();
      send_byte(8'h85, n);
      rq.push_back(7'h05);
      tq.push_back(tx_t'{8'h11, n + 2});
      send_byte(8'hEE, n);
      tick(3);
      check("overrun_set", 32'(bus.overrun), 32'd1);
      rd_byte(8'h00, 7'h06, 8'h22);
      frame_end(1);
      check("overrun_sticky", 32'(bus.overrun), 32'd1);
      check("frame_cnt_6", 32'(bus.frame_cnt), 32'd6);

      // Reset in the middle of a write frame with CS held active
      frame_begin();
      cmd_byte(8'h20);
      wr_byte(7'h20, 8'h01);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      check_reset_values();
      rst = 1'b0;
      tick(2);
      send_byte(8'h40, n);
      tick(2);
      send_byte(8'h55, n);
      tick(2);
      frame_end(0);
      check("frame_cnt_after_rst", 32'(bus.frame_cnt), 32'd0);
      frame_begin();
      cmd_byte(8'h30);
      wr_byte(7'h30, 8'h66);
      frame_end(1);
      check("frame_cnt_post_rst", 32'(bus.frame_cnt), 32'd1);
      frame_begin();
      rd_byte(8'hB0, 7'h30, 8'h66);
      frame_end(1);

      tick(5);
      check("wq_drained", 32'(wq.size()), 32'd0);
      check("rq_drained", 32'(rq.size()), 32'd0);
      check("tq_drained", 32'(tq.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/spi_reg_bridge.md
Name: spi_reg_bridge

Overview:
Consumes the byte stream produced by the SPI slave front-end and turns it into register-bus transactions.
- First byte of each CS frame is a command: bit7 = R/nW, bits[6:0] = start address.
- Following bytes are either written to consecutive registers, or answered with consecutive register reads loaded back into the SPI transmit path.
- Sits between the SPI slave and the FPGA register file/peripherals, all in the 100 MHz system domain.

Parameters:
ADDR_W, 7, register address width; command address field is bits[ADDR_W-1:0], and bits[6:ADDR_W] are ignored when ADDR_W < 7.
IDLE_TX, 8'hFF, byte offered to the SPI transmit path outside read data phases.

Ports:
clk  input  1  system clock, 100 MHz
rst  input  1  synchronous active-high reset
cs_active  input  1  SPI frame active (already synchronised, high during frame)
rx_byte  input  8  completed received byte
rx_valid  input  1  one-cycle pulse, rx_byte valid
tx_byte  output  8  byte for SPI slave to shift out on the next byte slot
tx_load  output  1  one-cycle pulse, tx_byte updated
reg_addr  output  ADDR_W  register address
reg_wdata  output  8  write data
reg_we  output  1  one-cycle write strobe
reg_re  output  1  one-cycle read strobe
reg_rdata  input  8  read data, valid exactly 1 cycle after reg_re
overrun  output  1  sticky: byte arrived while a read fetch was pending
frame_cnt  output  16  count of completed frames

Behaviour:
Reset (rst high at a clk edge):
- All outputs to 0, except tx_byte = IDLE_TX.
- FSM goes to IDLE; cs_active_d is cleared to 0.
Frame start/end:
- cs_active is registered as cs_active_d.
- Frame start = cs_active & ~cs_active_d.
- Frame end = ~cs_active & cs_active_d.
- A frame already in progress when reset is released is ignored until CS goes inactive and active again.
States:
- IDLE: wait for frame start -> CMD. tx_byte holds IDLE_TX.
- CMD: on rx_valid, latch reg_addr <= rx_byte[ADDR_W-1:0].
  - bit7 = 1: pulse reg_re the next cycle, go to RD_FETCH.
  - bit7 = 0: go to WR_DATA.
- RD_FETCH: one cycle after reg_re, tx_byte <= reg_rdata and tx_load pulses; go to RD_DATA.
  - Latency from command rx_valid to tx_load = 2 clk cycles.
- RD_DATA: on rx_valid (master's dummy byte, value ignored), reg_addr <= reg_addr+1, reg_re pulses the next cycle, go to RD_FETCH.
- WR_DATA: on rx_valid, reg_wdata <= rx_byte and reg_we pulses on the following cycle with the current reg_addr.
  - reg_addr increments the cycle after reg_we.
  - Stay in WR_DATA.
  - tx_byte <= rx_byte with tx_load pulse (echo).
Address arithmetic:
- Increment is modulo 2^ADDR_W: 2^ADDR_W-1 wraps to 0.
- No burst length limit.
Frame end (any state except IDLE):
- Go to IDLE next cycle; frame_cnt += 1 (wraps at 16'hFFFF -> 0).
- tx_byte <= IDLE_TX with tx_load pulse.
- A pending reg_re/reg_we already scheduled for that cycle still completes; no new strobes are issued.
Simultaneous events:
- rx_valid in the same cycle as frame end: the byte is dropped and no bus strobe is issued.
- rx_valid in RD_FETCH: set overrun (sticky until rst); the byte is ignored and the fetch completes normally.
- rx_valid in IDLE: ignored.
Strobe rules:
- reg_we and reg_re are never high together.
- Each strobe is exactly 1 cycle.

Test Plan:
1. Write burst:
   - Stimulus: frame with bytes 0x05, 0x11, 0x22, 0x33.
   - Required: reg_we at addr 5, 6, 7 with data 0x11, 0x22, 0x33; tx echoes 0x11, 0x22, 0x33; frame_cnt = 1 after CS high.
2. Read burst:
   - Stimulus: regs[0x10..0x12] = 0xA0, 0xA1, 0xA2; frame 0x90, 0x00, 0x00, 0x00.
   - Required: tx_load 2 cycles after each triggering rx_valid, with tx_byte 0xA0, 0xA1, 0xA2, then 0xA3's register; reg_re at 0x10..0x13.
3. Wrap-around:
   - Stimulus: write command 0x7F, data 0xAA, 0xBB.
   - Required: writes at addr 0x7F then 0x00.
4. Early CS release:
   - Stimulus: cs_active drops in the same cycle as rx_valid of a data byte in WR_DATA.
   - Required: no reg_we for that byte; tx_byte = 0xFF; FSM in IDLE.
5. Overrun:
   - Stimulus: in a read frame, rx_valid asserted 1 cycle after reg_re.
   - Required: overrun = 1 and stays 1; the fetched value is still loaded.
6. Reset mid-frame:
   - Stimulus: rst pulsed during WR_DATA with CS held low, then more bytes sent.
   - Required: outputs at reset values, no reg_we until CS toggles; the next frame operates normally.
